aes_decrypt_sequencer: RTL and testbench

Sequences one full AES-128 block decryption around the shared single-round inverse engine (InvShiftRows → InvSubBytes → AddRoundKey → InvMixCols). The block performs the initial AddRoundKey with round key 10 internally. It then issues nine full inverse rounds (keys 9..1) and one final round (key 0, InvMixCols bypassed) to the engine, fetching each round key from the expanded-key RAM. The result is presented on a valid/ready output port. The block sits between the decryption front end and the round engine, and owns the key-RAM read port.

---
 rtl/aes_decrypt_sequencer_if.sv | 32 +++
 rtl/aes_decrypt_sequencer.sv | 161 ++++++++++++++++
 tb/tb_aes_decrypt_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_decrypt_sequencer_if.sv
// Bus bundle between the AES decryption sequencer, its front end, the key RAM and the
// single-round inverse engine.
interface aes_decrypt_sequencer_if;
   logic         start_in;
   logic [127:0] block_in;
   logic         ready_out;
   logic         key_rd_out;
   logic [3:0]   key_addr_out;
   logic [127:0] key_data_in;
   logic         round_start_out;
   logic [127:0] round_block_out;
   logic [127:0] round_key_out;
   logic         round_last_out;
   logic         round_done_in;
   logic [127:0] round_result_in;
   logic         out_valid_o;
   logic [127:0] block_out;
   logic         out_ready_in;
   logic         error_out;

   modport master (
      input  start_in, block_in, key_data_in, round_done_in, round_result_in, out_ready_in,
      output ready_out, key_rd_out, key_addr_out, round_start_out, round_block_out,
             round_key_out, round_last_out, out_valid_o, block_out, error_out
   );

   modport slave (
      output start_in, block_in, key_data_in, round_done_in, round_result_in, out_ready_in,
      input  ready_out, key_rd_out, key_addr_out, round_start_out, round_block_out,
             round_key_out, round_last_out, out_valid_o, block_out, error_out
   );
endinterface

// File: rtl/aes_decrypt_sequencer.sv
// AES-128 block decryption sequencer: initial AddRoundKey with key 10, then ten rounds
// issued to a shared inverse-round engine with keys fetched from the expanded-key RAM.
module aes_decrypt_sequencer #(
   parameter int unsigned TIMEOUT = 64
) (
   input logic                     clk_in,
   input logic                     rst_n_in,
   aes_decrypt_sequencer_if.master bus
);

   localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StKeyReq,
      StKeyCap,
      StRoundWait,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [127:0]    st_q, st_d;
   logic [3:0]      r_q, r_d;
   logic [TmrW-1:0] tmr_q, tmr_d;
   logic            key_rd_q, key_rd_d;
   logic [3:0]      key_addr_q, key_addr_d;
   logic            round_start_q, round_start_d;
   logic [127:0]    round_block_q, round_block_d;
   logic [127:0]    round_key_q, round_key_d;
   logic            round_last_q, round_last_d;
   logic            out_valid_q, out_valid_d;
   logic [127:0]    block_out_q, block_out_d;
   logic            error_q, error_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= StIdle;
         st_q          <= '0;
         r_q           <= '0;
         tmr_q         <= '0;
         key_rd_q      <= 1'b0;
         key_addr_q    <= '0;
         round_start_q <= 1'b0;
         round_block_q <= '0;
         round_key_q   <= '0;
         round_last_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         block_out_q   <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         st_q          <= st_d;
         r_q           <= r_d;
         tmr_q         <= tmr_d;
         key_rd_q      <= key_rd_d;
         key_addr_q    <= key_addr_d;
         round_start_q <= round_start_d;
         round_block_q <= round_block_d;
         round_key_q   <= round_key_d;
         round_last_q  <= round_last_d;
         out_valid_q   <= out_valid_d;
         block_out_q   <= block_out_d;
         error_q       <= error_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      st_d          = st_q;
      r_d           = r_q;
      tmr_d         = tmr_q;
      key_rd_d      = 1'b0;
      key_addr_d    = key_addr_q;
      round_start_d = 1'b0;
      round_block_d = round_block_q;
      round_key_d   = round_key_q;
      round_last_d  = round_last_q;
      out_valid_d   = out_valid_q;
      block_out_d   = block_out_q;
      error_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start_in) begin
               st_d       = bus.block_in;
               r_d        = 4'd10;
               key_addr_d = 4'd10;
               key_rd_d   = 1'b1;
               state_d    = StKeyReq;
            end
         end

         StKeyReq: begin
            state_d = StKeyCap;
         end

         StKeyCap: begin
            if (r_q == 4'd10) begin
               // Key 10 is only whitened in, never sent to the engine.
               st_d       = st_q ^ bus.key_data_in;
               r_d        = 4'd9;
               key_addr_d = 4'd9;
               key_rd_d   = 1'b1;
               state_d    = StKeyReq;
            end else begin
               round_block_d = st_q;
               round_key_d   = bus.key_data_in;
               round_last_d  = (r_q == 4'd0);
               round_start_d = 1'b1;
               tmr_d         = '0;
               state_d       = StRoundWait;
            end
         end

         StRoundWait: begin
            if (bus.round_done_in) begin
               st_d = bus.round_result_in;
               if (r_q == 4'd0) begin
                  block_out_d = bus.round_result_in;
                  out_valid_d = 1'b1;
                  state_d     = StDone;
               end else begin
                  r_d        = r_q - 4'd1;
                  key_addr_d = r_q - 4'd1;
                  key_rd_d   = 1'b1;
                  state_d    = StKeyReq;
               end
            end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
               error_d      = 1'b1;
               round_last_d = 1'b0;
               state_d      = StIdle;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         StDone: begin
            if (bus.out_ready_in) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.ready_out       = (state_q == StIdle);
   assign bus.key_rd_out      = key_rd_q;
   assign bus.key_addr_out    = key_addr_q;
   assign bus.round_start_out = round_start_q;
   assign bus.round_block_out = round_block_q;
   assign bus.round_key_out   = round_key_q;
   assign bus.round_last_out  = round_last_q;
   assign bus.out_valid_o     = out_valid_q;
   assign bus.block_out       = block_out_q;
   assign bus.error_out       = error_q;

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer: models key RAM and inverse-round engine, checks known
// answers, timing, backpressure, timeout, async reset and spurious inputs.
module tb_aes_decrypt_sequencer;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           lat;
      int           bp;
      int           exp_cyc;
   } vec_t;

   logic clk_in = 1'b0;
   logic rst_n_in = 1'b0;
   aes_decrypt_sequencer_if bus ();

   aes_decrypt_sequencer #(.TIMEOUT(64)) dut (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .bus     (bus)
   );

   always #5 clk_in = ~clk_in;

   int           n_checks = 0;
   int           n_err = 0;
   logic [7:0]   sbox[256];
   logic [7:0]   isbox[256];
   logic [127:0] ram[11];
   int           cyc = 0;
   int           lat_mode = 1;
   int           stray_req = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Passive recording of DUT activity, sampled on the edge that ends each cycle.
   int           acc_cnt = 0, acc_cyc = 0, err_cnt = 0, vld_cnt = 0, long_pulse = 0;
   logic         vld_prev = 1'b0, start_prev = 1'b0;
   int           rd_q[$];
   logic         iss_last_q[$];
   logic [127:0] iss_blk_q[$];
   logic [127:0] res_q[$];

   always @(posedge clk_in) begin
      if (rst_n_in) begin
         if (bus.ready_out && bus.start_in) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
         end
         if (bus.key_rd_out) rd_q.push_back(int'(bus.key_addr_out));
         if (bus.round_start_out) begin
            iss_last_q.push_back(bus.round_last_out);
            iss_blk_q.push_back(bus.round_block_out);
         end
         if (bus.round_start_out && start_prev) long_pulse <= long_pulse + 1;
         if (bus.error_out) err_cnt <= err_cnt + 1;
         if (bus.out_valid_o && !vld_prev) vld_cnt <= vld_cnt + 1;
      end
      vld_prev   <= bus.out_valid_o;
      start_prev <= bus.round_start_out;
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         end
         b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x]  = b;
         isbox[b] = 8'(x);
      end
   endtask

   // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   a[16];
      logic [7:0]   c[4];
      logic [127:0] u;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++)
            u[127-8*(r+4*cc) -: 8] = isbox[a[r + 4*((cc - r + 4) % 4)]];
      u = u ^ k;
      if (last) return u;
      for (int cc = 0; cc < 4; cc++) begin
         for (int r = 0; r < 4; r++) c[r] = u[127-8*(r+4*cc) -: 8];
         u[127-8*(4*cc+0) -: 8] = gmul(c[0],8'h0e)^gmul(c[1],8'h0b)^gmul(c[2],8'h0d)^gmul(c[3],8'h09);
         u[127-8*(4*cc+1) -: 8] = gmul(c[0],8'h09)^gmul(c[1],8'h0e)^gmul(c[2],8'h0b)^gmul(c[3],8'h0d);
         u[127-8*(4*cc+2) -: 8] = gmul(c[0],8'h0d)^gmul(c[1],8'h09)^gmul(c[2],8'h0e)^gmul(c[3],8'h0b);
         u[127-8*(4*cc+3) -: 8] = gmul(c[0],8'h0b)^gmul(c[1],8'h0d)^gmul(c[2],8'h09)^gmul(c[3],8'h0e);
      end
      return u;
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w[44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) ram[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
      logic [127:0] s;
      s = ct ^ ram[10];
      for (int r = 9; r >= 1; r--) s = inv_round(s, ram[r], 1'b0);
      return inv_round(s, ram[0], 1'b1);
   endfunction

   // Key RAM (one-cycle read latency) and round engine with programmable latency.
   initial begin : engine
      int           stray_done, due, eiss, rda, l;
      logic         pend, rdp, elast;
      logic [127:0] eblk, ekey;
      stray_done = 0; due = 0; eiss = 0; rda = 0; pend = 1'b0; rdp = 1'b0; elast = 1'b0;
      eblk = '0; ekey = '0;
      bus.round_done_in = 1'b0; bus.round_result_in = '0; bus.key_data_in = '0;
      forever begin
         @(posedge clk_in); #1;
         if (!rst_n_in) begin
            pend = 1'b0; eiss = 0; rdp = 1'b0; bus.round_done_in = 1'b0;
         end else begin
            bus.key_data_in = (rdp && rda <= 10) ? ram[rda] : rnd128();
            rdp = bus.key_rd_out;
            rda = int'(bus.key_addr_out);
            bus.round_done_in   = 1'b0;
            bus.round_result_in = rnd128();
            if (pend && cyc == due) begin
               bus.round_done_in   = 1'b1;
               bus.round_result_in = inv_round(eblk, ekey, elast);
               res_q.push_back(bus.round_result_in);
               pend = 1'b0;
            end
            if (stray_req != stray_done) begin
               stray_done++;
               bus.round_done_in = 1'b1;
            end
            if (bus.round_start_out) begin
               l = (lat_mode < 0) ? ((eiss % 2 == 0) ? 1 : 7) : lat_mode;
               eiss++;
               eblk = bus.round_block_out; ekey = bus.round_key_out; elast = bus.round_last_out;
               if (l > 0) begin pend = 1'b1; due = cyc + l; end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_in); #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, 128'(bus.ready_out), 128'd1);
      chk({tag, "_ctrl"}, 128'({bus.key_rd_out, bus.key_addr_out, bus.round_start_out,
                                bus.round_last_out, bus.out_valid_o, bus.error_out}), 128'd0);
      chk({tag, "_rblk"}, bus.round_block_out, 128'd0);
      chk({tag, "_rkey"}, bus.round_key_out, 128'd0);
      chk({tag, "_bout"}, bus.block_out, 128'd0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.ready_out && n < 200) begin step(); n++; end
      chk({tag, "_ready_wait"}, 128'(bus.ready_out), 128'd1);
   endtask

   task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                            input logic [127:0] pt, input int lat, input int bp,
                            input int exp_cyc, input string tag);
      int           bi, ii, ri, n, v;
      logic         ok;
      logic [127:0] held;
      expand(key);
      lat_mode = lat;
      wait_ready(tag);
      bi = rd_q.size(); ii = iss_last_q.size(); ri = res_q.size();
      bus.block_in = ct; bus.start_in = 1'b1;
      step();
      bus.start_in = 1'b0; bus.block_in = rnd128();
      n = 0;
      while (!bus.out_valid_o && n < 2000) begin step(); n++; end
      chk({tag, "_valid_seen"}, 128'(bus.out_valid_o), 128'd1);
      v = cyc;
      if (exp_cyc >= 0) chk({tag, "_valid_cycle"}, 128'(v - acc_cyc), 128'(exp_cyc));
      chk({tag, "_plaintext"}, bus.block_out, pt);
      ok = (rd_q.size() - bi == 11);
      for (int k = 0; k < 11 && ok; k++) if (rd_q[bi+k] != 10 - k) ok = 1'b0;
      chk({tag, "_key_addrs"}, 128'(ok), 128'd1);
      ok = (iss_last_q.size() - ii == 10);
      for (int k = 0; k < 10 && ok; k++) if (iss_last_q[ii+k] != (k == 9)) ok = 1'b0;
      chk({tag, "_last_flag"}, 128'(ok), 128'd1);
      ok = (iss_blk_q.size() - ii == 10) && (res_q.size() - ri == 10) &&
           (iss_blk_q[ii] == (ct ^ ram[10]));
      for (int k = 1; k < 10 && ok; k++) if (iss_blk_q[ii+k] != res_q[ri+k-1]) ok = 1'b0;
      chk({tag, "_block_chain"}, 128'(ok), 128'd1);
      if (bp > 0) begin
         held = bus.block_out;
         ok = 1'b1;
         for (int k = 0; k < bp; k++) begin
            if (k == 2) begin bus.start_in = 1'b1; stray_req++; end
            if (k == 3) bus.start_in = 1'b0;
            step();
            if (bus.block_out !== held || bus.ready_out || !bus.out_valid_o) ok = 1'b0;
         end
         bus.start_in = 1'b0;
         chk({tag, "_bp_hold"}, 128'(ok), 128'd1);
      end
      bus.out_ready_in = 1'b1;
      step();
      bus.out_ready_in = 1'b0;
      chk({tag, "_ready_after"}, 128'({bus.ready_out, bus.out_valid_o}), 128'b10);
      step();
      chk({tag, "_not_queued"}, 128'({bus.ready_out, bus.key_rd_out}), 128'b10);
   endtask

   initial begin : main
      vec_t         vt[4];
      logic [127:0] k, c, p;
      int           n, l, eb, vb, ii, ab, rb;
      int           vc[3];
      logic         ok;

      vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 1, 0, 43};
      vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 2, 20, 53};
      vt[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a, 4, 0, 73};
      vt[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 3, 5, 63};

      build_tables();
      bus.start_in = 1'b0; bus.block_in = '0; bus.out_ready_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk_reset("reset");
      rst_n_in = 1'b1;
      step();

      for (int i = 0; i < 4; i++)
         run_block(vt[i].key, vt[i].ct, vt[i].pt, vt[i].lat, vt[i].bp, vt[i].exp_cyc, "kat");

      // Alternating 1/7 engine latency.
      k = rnd128(); c = rnd128(); expand(k); p = ref_decrypt(c);
      run_block(k, c, p, -1, 0, -1, "alt_lat");

      // Engine never answers.
      expand(vt[0].key);
      lat_mode = 0;
      wait_ready("to");
      eb = err_cnt; vb = vld_cnt;
      bus.block_in = vt[0].ct; bus.start_in = 1'b1;
      step();
      bus.start_in = 1'b0;
      n = 0;
      while (!bus.error_out && n < 300) begin step(); n++; end
      chk("to_seen", 128'(bus.error_out), 128'd1);
      chk("to_cycle", 128'(cyc - acc_cyc), 128'd69);
      chk("to_ready", 128'(bus.ready_out), 128'd1);
      repeat (10) step();
      chk("to_single", 128'(err_cnt - eb), 128'd1);
      chk("to_no_valid", 128'(vld_cnt - vb), 128'd0);
      run_block(vt[0].key, vt[0].ct, vt[0].pt, 1, 0, 43, "after_to");

      // Asynchronous reset during round 5, then a stray engine completion.
      expand(vt[0].key);
      lat_mode = 7;
      wait_ready("ar");
      ii = iss_last_q.size();
      bus.block_in = vt[0].ct; bus.start_in = 1'b1;
      step();
      bus.start_in = 1'b0;
      n = 0;
      while (iss_last_q.size() - ii < 5 && n < 500) begin step(); n++; end
      chk("ar_reached_r5", 128'(iss_last_q.size() - ii), 128'd5);
      #3 rst_n_in = 1'b0;
      #1 chk_reset("ar");
      @(posedge clk_in);
      @(posedge clk_in);
      #3 rst_n_in = 1'b1;
      step();
      stray_req++;
      ok = 1'b1;
      repeat (4) begin
         step();
         if (!bus.ready_out || bus.key_rd_out || bus.round_start_out || bus.out_valid_o) ok = 1'b0;
      end
      chk("ar_stray_ignored", 128'(ok), 128'd1);
      run_block(vt[0].key, vt[0].ct, vt[0].pt, 1, 0, 43, "after_ar");

      // start_in held high with out_ready_in high: one accept per handshake.
      k = rnd128(); c = rnd128(); expand(k); p = ref_decrypt(c);
      lat_mode = 1;
      wait_ready("held");
      ab = acc_cnt; rb = rd_q.size();
      bus.out_ready_in = 1'b1; bus.block_in = c; bus.start_in = 1'b1;
      for (int b = 0; b < 3; b++) begin
         n = 0;
         step();
         while (!bus.out_valid_o && n < 200) begin step(); n++; end
         chk("held_plaintext", bus.block_out, p);
         vc[b] = cyc;
         if (b == 2) bus.start_in = 1'b0;
         step();
         chk("held_ready_next", 128'(bus.ready_out), 128'd1);
      end
      bus.out_ready_in = 1'b0;
      repeat (3) step();
      chk("held_gap1", 128'(vc[1] - vc[0]), 128'd44);
      chk("held_gap2", 128'(vc[2] - vc[1]), 128'd44);
      chk("held_accepts", 128'(acc_cnt - ab), 128'd3);
      chk("held_key_reads", 128'(rd_q.size() - rb), 128'd33);

      for (int i = 0; i < 6; i++) begin
         k = rnd128(); c = rnd128(); expand(k); p = ref_decrypt(c);
         l = int'($urandom_range(1, 6));
         run_block(k, c, p, l, int'($urandom_range(0, 3)), 33 + 10 * l, "rand");
      end

      chk("start_pulse_width", 128'(long_pulse), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
